// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencer: array control-state codes
// driven onto o_ctrl_state and the sequencer's own FSM state type.
package sa_pkg;

  localparam int CTRL_WIDTH = 4;

  localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = 4'd0;
  localparam logic [CTRL_WIDTH-1:0] CTRL_WARMUP = 4'd1;
  localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = 4'd2;
  localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_STEADY,
    S_DRAIN,
    S_READOUT
  } seq_state_e;

endpackage

// File: rtl/sa_op_sequencer_if.sv
// Result-buffer read port plus the outgoing result stream of the sequencer.
// The master side is the sequencer; the slave side is the buffer/consumer.
interface sa_op_sequencer_if #(
  parameter int NUM_COL              = 4,
  parameter int ACCU_DATA_WIDTH      = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 5
);

  localparam int DW = NUM_COL * ACCU_DATA_WIDTH;

  logic                            o_down_rd_en;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_addr;
  logic [DW-1:0]                   i_down_rd_data;

  logic                            o_res_valid;
  logic                            i_res_ready;
  logic [DW-1:0]                   o_res_data;
  logic                            o_res_last;

  modport master (
    output o_down_rd_en,
    output o_down_rd_addr,
    input  i_down_rd_data,
    output o_res_valid,
    input  i_res_ready,
    output o_res_data,
    output o_res_last
  );

  modport slave (
    input  o_down_rd_en,
    input  o_down_rd_addr,
    output i_down_rd_data,
    input  o_res_valid,
    output i_res_ready,
    input  o_res_data,
    input  o_res_last
  );

endinterface

// File: rtl/sa_res_stream.sv
// Readout engine: fetches NUM_ROW result words from base+0..NUM_ROW-1 and streams them
// over valid/ready, keeping at most one buffer read in flight.
module sa_res_stream #(
  parameter int NUM_ROW    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_last_accept
);

  localparam int IDX_W = $clog2(NUM_ROW + 1);
  localparam logic [IDX_W-1:0] ROW_CNT  = IDX_W'(NUM_ROW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROW - 1);

  logic                  r_active;
  logic                  r_inflight;
  logic [IDX_W-1:0]      r_issued;
  logic [IDX_W-1:0]      r_captured;
  logic                  r_valid;
  logic                  r_last;
  logic [DATA_WIDTH-1:0] r_data;

  logic w_accept;
  logic w_issue;

  // A new read may go out in the same cycle the held word is taken, never earlier.
  assign w_accept = r_valid && i_ready;
  assign w_issue  = r_active && !r_inflight && (r_issued != ROW_CNT) &&
                    (!r_valid || w_accept);

  assign o_rd_en       = w_issue;
  assign o_rd_addr     = i_base + ADDR_WIDTH'(r_issued);
  assign o_valid       = r_valid;
  assign o_data        = r_data;
  assign o_last        = r_last;
  assign o_last_accept = w_accept && r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active   <= 1'b0;
      r_inflight <= 1'b0;
      r_issued   <= '0;
      r_captured <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_inflight <= w_issue;

      if (i_start) begin
        r_active <= 1'b1;
        r_issued <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + IDX_W'(1);
        if (o_last_accept) r_active <= 1'b0;
      end

      if (i_start) r_captured <= '0;
      else if (r_inflight) r_captured <= r_captured + IDX_W'(1);

      // Buffer data lands one cycle after the read; it becomes the held word here.
      if (r_inflight) begin
        r_data  <= i_rd_data;
        r_valid <= 1'b1;
        r_last  <= (r_captured == LAST_IDX);
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sa_op_sequencer.sv
// Operation sequencer for the systolic array: drives warmup/steady/drain phases and
// operand read ranges, then hands off to sa_res_stream to read out the results.
module sa_op_sequencer #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int ACCU_DATA_WIDTH      = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = sa_pkg::CTRL_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_len,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_base,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_base,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_base,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  sa_op_sequencer_if.master               bus
);

  import sa_pkg::*;

  localparam int LD = LOG2_SRAM_BANK_DEPTH;
  localparam int DW = NUM_COL * ACCU_DATA_WIDTH;
  // Sized for the longest phase (len_max + NUM_ROW + NUM_COL) with headroom.
  localparam int CNT_W = LD + $clog2(NUM_ROW + NUM_COL) + 1;

  seq_state_e       r_state;
  seq_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [LD-1:0]    r_len;
  logic             r_busy;
  logic             r_done;
  logic [LD-1:0]    r_top_start;
  logic [LD-1:0]    r_top_end;
  logic [LD-1:0]    r_left_start;
  logic [LD-1:0]    r_left_end;
  logic [LD-1:0]    r_down_start;
  logic [LD-1:0]    r_down_end;

  logic w_accept;
  logic w_phase_end;
  logic w_ro_start;
  logic w_last_accept;

  assign w_accept = i_start && (r_state == S_IDLE) && !r_busy && (i_len != '0);

  always_comb begin
    w_state_next = r_state;
    w_phase_end  = 1'b0;
    w_ro_start   = 1'b0;
    o_ctrl_state = CTRL_WIDTH'(CTRL_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_WARMUP;
      end
      S_WARMUP: begin
        o_ctrl_state = CTRL_WIDTH'(CTRL_WARMUP);
        if (r_cnt == CNT_W'(r_len)) begin
          w_phase_end  = 1'b1;
          w_state_next = S_STEADY;
        end
      end
      S_STEADY: begin
        o_ctrl_state = CTRL_WIDTH'(CTRL_STEADY);
        if ((r_cnt + CNT_W'(1)) == (CNT_W'(r_len) + CNT_W'(NUM_ROW + NUM_COL - 2))) begin
          w_phase_end  = 1'b1;
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_ctrl_state = CTRL_WIDTH'(CTRL_DRAIN);
        if (r_cnt == CNT_W'(NUM_ROW - 1)) begin
          w_phase_end  = 1'b1;
          w_ro_start   = 1'b1;
          w_state_next = S_READOUT;
        end
      end
      S_READOUT: begin
        if (w_last_accept) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Busy drops only after the done cycle, which also keeps a start in the done cycle out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_len        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_top_start  <= '0;
      r_top_end    <= '0;
      r_left_start <= '0;
      r_left_end   <= '0;
      r_down_start <= '0;
      r_down_end   <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last_accept;

      if (w_phase_end || (r_state == S_IDLE) || (r_state == S_READOUT)) r_cnt <= '0;
      else r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept) begin
        r_busy       <= 1'b1;
        r_len        <= i_len;
        r_top_start  <= i_top_base;
        r_top_end    <= i_top_base + i_len;
        r_left_start <= i_left_base;
        r_left_end   <= i_left_base + i_len;
        r_down_start <= i_down_base;
        r_down_end   <= i_down_base + i_len;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy                    = r_busy;
  assign o_done                    = r_done;
  assign o_top_sram_rd_start_addr  = r_top_start;
  assign o_top_sram_rd_end_addr    = r_top_end;
  assign o_left_sram_rd_start_addr = r_left_start;
  assign o_left_sram_rd_end_addr   = r_left_end;
  assign o_down_sram_rd_start_addr = r_down_start;
  assign o_down_sram_rd_end_addr   = r_down_end;

  sa_res_stream #(
    .NUM_ROW   (NUM_ROW),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(LD)
  ) u_res_stream (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_ro_start),
    .i_base       (r_down_start),
    .o_rd_en      (bus.o_down_rd_en),
    .o_rd_addr    (bus.o_down_rd_addr),
    .i_rd_data    (bus.i_down_rd_data),
    .o_valid      (bus.o_res_valid),
    .i_ready      (bus.i_res_ready),
    .o_data       (bus.o_res_data),
    .o_last       (bus.o_res_last),
    .o_last_accept(w_last_accept)
  );

endmodule

// File: tb/tb_sa_op_sequencer.sv
// Bench for sa_op_sequencer: operations with random lengths, bases and back-pressure,
// checked against phase lengths, ranges and readout data derived from the operands.
module tb_sa_op_sequencer;

  localparam int NR    = 4;
  localparam int NC    = 4;
  localparam int ADW   = 32;
  localparam int LD    = 5;
  localparam int CW    = 4;
  localparam int DW    = NC * ADW;
  localparam int DEPTH = 1 << LD;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [LD-1:0] i_len, i_top_base, i_left_base, i_down_base;
  logic          o_busy, o_done;
  logic [CW-1:0] o_ctrl_state;
  logic [LD-1:0] top_s, top_e, left_s, left_e, down_s, down_e;

  sa_op_sequencer_if #(.NUM_COL(NC), .ACCU_DATA_WIDTH(ADW), .LOG2_SRAM_BANK_DEPTH(LD)) bus ();

  sa_op_sequencer #(
    .NUM_ROW(NR), .NUM_COL(NC), .ACCU_DATA_WIDTH(ADW),
    .LOG2_SRAM_BANK_DEPTH(LD), .CTRL_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_len(i_len),
    .i_top_base(i_top_base), .i_left_base(i_left_base), .i_down_base(i_down_base),
    .o_busy(o_busy), .o_done(o_done), .o_ctrl_state(o_ctrl_state),
    .o_top_sram_rd_start_addr(top_s), .o_top_sram_rd_end_addr(top_e),
    .o_left_sram_rd_start_addr(left_s), .o_left_sram_rd_end_addr(left_e),
    .o_down_sram_rd_start_addr(down_s), .o_down_sram_rd_end_addr(down_e),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Result buffer model: synchronous read, data one cycle after the enable.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.o_down_rd_en) bus.i_down_rd_data <= mem[bus.o_down_rd_addr];

  int nCompared   = 0;
  int nMismatched = 0;

  int            obsCtrl[$];
  int            obsAddr[$];
  logic [DW-1:0] obsData[$];
  logic          obsLast[$];
  int            doneCycles, stallViol, readViol, busyViol, stallCycles;
  logic          busyAfter;
  bit            timedOut;

  function automatic int runLen(input int from, input int v);
    int n = 0;
    while ((from + n) < obsCtrl.size() && obsCtrl[from + n] == v) n++;
    return n;
  endfunction

  // Runs one operation; readyPct < 0 selects ready high one cycle in three.
  task automatic run_op(input int len, input int topB, input int leftB, input int downB,
                        input int readyPct, input int pokeCycle, input int pokeLen);
    int            doneAt;
    bit            prevStall, prevRd;
    logic [DW-1:0] prevData;
    logic          prevLast;
    obsCtrl.delete(); obsAddr.delete(); obsData.delete(); obsLast.delete();
    doneCycles = 0; stallViol = 0; readViol = 0; busyViol = 0; stallCycles = 0;
    busyAfter = 1'b1; timedOut = 1'b0; doneAt = -1;
    prevStall = 1'b0; prevRd = 1'b0; prevData = '0; prevLast = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    i_start = 1'b1; i_len = LD'(len);
    i_top_base = LD'(topB); i_left_base = LD'(leftB); i_down_base = LD'(downB);
    bus.i_res_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.i_res_ready = (readyPct < 0) ? (cyc % 3 == 2) : ($urandom_range(0, 99) < readyPct);
      if (cyc == pokeCycle) begin
        i_start = 1'b1; i_len = LD'(pokeLen); i_top_base = LD'(topB + 3);
      end else begin
        i_start = 1'b0;
      end
      #1;
      if (doneAt < 0) obsCtrl.push_back(int'(o_ctrl_state));
      if (doneAt < 0 && !o_busy) busyViol++;
      if (doneAt >= 0 && cyc == doneAt + 1) busyAfter = o_busy;
      if (o_done) begin
        doneCycles++;
        if (doneAt < 0) doneAt = cyc;
      end
      if (bus.o_down_rd_en) obsAddr.push_back(int'(bus.o_down_rd_addr));
      if (bus.o_down_rd_en && (prevRd || (bus.o_res_valid && !bus.i_res_ready))) readViol++;
      if (prevStall && (!bus.o_res_valid || bus.o_res_data !== prevData || bus.o_res_last !== prevLast))
        stallViol++;
      if (bus.o_res_valid && bus.i_res_ready) begin
        obsData.push_back(bus.o_res_data);
        obsLast.push_back(bus.o_res_last);
      end
      prevStall = bus.o_res_valid && !bus.i_res_ready;
      if (prevStall) stallCycles++;
      prevData = bus.o_res_data; prevLast = bus.o_res_last; prevRd = bus.o_down_rd_en;
      if (doneAt >= 0 && cyc >= doneAt + 3) break;
      @(negedge clk);
    end
    if (doneAt < 0) timedOut = 1'b1;
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; i_len = '0;
    i_top_base = '0; i_left_base = '0; i_down_base = '0;
    bus.i_res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nCompared++;
    if ({o_busy, o_done, o_ctrl_state} !== 6'd0) begin
      nMismatched++; $display("[TB] FAIL reset_ctrl: got %h expected 00", {o_busy, o_done, o_ctrl_state});
    end
    nCompared++;
    if ({top_s, top_e, left_s, left_e, down_s, down_e, bus.o_down_rd_addr} !== 35'd0) begin
      nMismatched++; $display("[TB] FAIL reset_addr: got %h expected 0",
                              {top_s, top_e, left_s, left_e, down_s, down_e, bus.o_down_rd_addr});
    end
    nCompared++;
    if ({bus.o_down_rd_en, bus.o_res_valid, bus.o_res_last} !== 3'd0 || bus.o_res_data !== '0) begin
      nMismatched++; $display("[TB] FAIL reset_stream: got en/v/l %b%b%b data %h expected all 0",
                              bus.o_down_rd_en, bus.o_res_valid, bus.o_res_last, bus.o_res_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int w, s, d;
    run_op(4, 0, 0, 0, 100, -1, 0);
    nCompared++;
    if (timedOut) begin nMismatched++; $display("[TB] FAIL basic_timeout: got no done expected done"); end
    w = runLen(0, 1); s = runLen(w, 2); d = runLen(w + s, 3);
    nCompared++;
    if (w != 5 || s != 10 || d != 4) begin
      nMismatched++; $display("[TB] FAIL basic_phases: got %0d/%0d/%0d expected 5/10/4", w, s, d);
    end
    nCompared++;
    if ({top_s, top_e, left_s, left_e, down_s, down_e} !== {5'd0, 5'd4, 5'd0, 5'd4, 5'd0, 5'd4}) begin
      nMismatched++; $display("[TB] FAIL basic_ranges: got %h expected 0->4 on all",
                              {top_s, top_e, left_s, left_e, down_s, down_e});
    end
    for (int i = 0; i < NR; i++) begin
      nCompared++;
      if ((i < obsAddr.size() ? obsAddr[i] : -1) != i || (i < obsData.size() ? obsData[i] : '0) !== mem[i] ||
          (i < obsLast.size() ? obsLast[i] : 1'bx) !== (i == NR - 1)) begin
        nMismatched++; $display("[TB] FAIL basic_beat%0d: got addr %0d data %h expected addr %0d data %h",
                                i, (i < obsAddr.size() ? obsAddr[i] : -1),
                                (i < obsData.size() ? obsData[i] : '0), i, mem[i]);
      end
    end
    nCompared++;
    if (doneCycles != 1 || busyAfter !== 1'b0 || busyViol != 0 || obsData.size() != NR) begin
      nMismatched++; $display("[TB] FAIL basic_done: got done %0d busyAfter %b busyViol %0d beats %0d expected 1/0/0/%0d",
                              doneCycles, busyAfter, busyViol, obsData.size(), NR);
    end
  endtask

  task automatic test_backpressure();
    run_op(4, 5, 6, 7, -1, -1, 0);
    nCompared++;
    if (stallViol != 0 || readViol != 0 || stallCycles == 0) begin
      nMismatched++; $display("[TB] FAIL bp_hold: got stallViol %0d readViol %0d stalls %0d expected 0/0/>0",
                              stallViol, readViol, stallCycles);
    end
    nCompared++;
    if (obsData.size() != NR || doneCycles != 1) begin
      nMismatched++; $display("[TB] FAIL bp_count: got beats %0d done %0d expected %0d/1", obsData.size(), doneCycles, NR);
    end
    for (int i = 0; i < NR; i++) begin
      nCompared++;
      if ((i < obsData.size() ? obsData[i] : '0) !== mem[(7 + i) % DEPTH] ||
          (i < obsLast.size() ? obsLast[i] : 1'bx) !== (i == NR - 1)) begin
        nMismatched++; $display("[TB] FAIL bp_beat%0d: got %h expected %h", i,
                                (i < obsData.size() ? obsData[i] : '0), mem[(7 + i) % DEPTH]);
      end
    end
  endtask

  task automatic test_wrap();
    run_op(4, 30, 1, 30, 100, -1, 0);
    nCompared++;
    if ({top_s, top_e, down_s, down_e} !== {5'd30, 5'd2, 5'd30, 5'd2}) begin
      nMismatched++; $display("[TB] FAIL wrap_range: got top %0d->%0d down %0d->%0d expected 30->2",
                              top_s, top_e, down_s, down_e);
    end
    for (int i = 0; i < NR; i++) begin
      nCompared++;
      if ((i < obsAddr.size() ? obsAddr[i] : -1) != (30 + i) % DEPTH ||
          (i < obsData.size() ? obsData[i] : '0) !== mem[(30 + i) % DEPTH]) begin
        nMismatched++; $display("[TB] FAIL wrap_read%0d: got addr %0d expected %0d", i,
                                (i < obsAddr.size() ? obsAddr[i] : -1), (30 + i) % DEPTH);
      end
    end
  endtask

  task automatic test_ignored_start();
    int idleViol = 0;
    int w, s;
    @(negedge clk);
    i_start = 1'b1; i_len = '0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (o_busy || o_done || o_ctrl_state != 0) idleViol++;
      @(negedge clk);
    end
    nCompared++;
    if (idleViol != 0) begin nMismatched++; $display("[TB] FAIL len0_start: got %0d busy cycles expected 0", idleViol); end
    run_op(5, 9, 10, 11, 100, 5 + 3, 7);
    w = runLen(0, 1); s = runLen(w, 2);
    nCompared++;
    if (w != 6 || s != 5 + NR + NC - 2 || doneCycles != 1) begin
      nMismatched++; $display("[TB] FAIL busy_start: got warm %0d steady %0d done %0d expected 6/%0d/1",
                              w, s, doneCycles, 5 + NR + NC - 2);
    end
    nCompared++;
    if ({top_s, top_e} !== {5'd9, 5'd14}) begin
      nMismatched++; $display("[TB] FAIL busy_start_range: got %0d->%0d expected 9->14", top_s, top_e);
    end
  endtask

  task automatic test_abort();
    bit reached = 1'b0;
    int dones = 0;
    int w, s, d;
    @(negedge clk);
    i_start = 1'b1; i_len = 5'd6; i_top_base = 5'd3; i_left_base = 5'd4; i_down_base = 5'd5;
    bus.i_res_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_ctrl_state == 4'd2) begin reached = 1'b1; break; end
    end
    nCompared++;
    if (!reached) begin nMismatched++; $display("[TB] FAIL abort_reach: got no STEADY expected STEADY"); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    nCompared++;
    if ({o_busy, o_done, o_ctrl_state, bus.o_down_rd_en, bus.o_res_valid, bus.o_res_last} !== 9'd0 ||
        bus.o_res_data !== '0) begin
      nMismatched++; $display("[TB] FAIL abort_ctrl: got %b expected 0",
                              {o_busy, o_done, o_ctrl_state, bus.o_down_rd_en, bus.o_res_valid, bus.o_res_last});
    end
    nCompared++;
    if ({top_s, top_e, left_s, left_e, down_s, down_e, bus.o_down_rd_addr} !== 35'd0) begin
      nMismatched++; $display("[TB] FAIL abort_addr: got %h expected 0",
                              {top_s, top_e, left_s, left_e, down_s, down_e, bus.o_down_rd_addr});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    nCompared++;
    if (dones != 0) begin nMismatched++; $display("[TB] FAIL abort_nodone: got %0d active cycles expected 0", dones); end
    run_op(3, 2, 2, 12, 70, -1, 0);
    w = runLen(0, 1); s = runLen(w, 2); d = runLen(w + s, 3);
    nCompared++;
    if (w != 4 || s != 3 + NR + NC - 2 || d != NR || doneCycles != 1 || obsData.size() != NR) begin
      nMismatched++; $display("[TB] FAIL abort_rerun: got %0d/%0d/%0d done %0d beats %0d expected 4/%0d/%0d/1/%0d",
                              w, s, d, doneCycles, obsData.size(), 3 + NR + NC - 2, NR, NR);
    end
  endtask

  task automatic test_random();
    int len, tB, lB, dB, pct, w, s, d;
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, DEPTH - 1);
      tB = $urandom_range(0, DEPTH - 1); lB = $urandom_range(0, DEPTH - 1); dB = $urandom_range(0, DEPTH - 1);
      pct = $urandom_range(30, 100);
      run_op(len, tB, lB, dB, pct, -1, 0);
      nCompared++;
      if (timedOut) begin nMismatched++; $display("[TB] FAIL rnd%0d_timeout: got no done expected done", k); end
      w = runLen(0, 1); s = runLen(w, 2); d = runLen(w + s, 3);
      nCompared++;
      if (w != len + 1 || s != len + NR + NC - 2 || d != NR) begin
        nMismatched++; $display("[TB] FAIL rnd%0d_phases: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                k, w, s, d, len + 1, len + NR + NC - 2, NR);
      end
      nCompared++;
      if ({top_s, top_e, left_s, left_e, down_s, down_e} !==
          {LD'(tB), LD'((tB + len) % DEPTH), LD'(lB), LD'((lB + len) % DEPTH), LD'(dB), LD'((dB + len) % DEPTH)}) begin
        nMismatched++; $display("[TB] FAIL rnd%0d_ranges: got %0d->%0d %0d->%0d %0d->%0d expected len %0d from %0d/%0d/%0d",
                                k, top_s, top_e, left_s, left_e, down_s, down_e, len, tB, lB, dB);
      end
      for (int i = 0; i < NR; i++) begin
        nCompared++;
        if ((i < obsAddr.size() ? obsAddr[i] : -1) != (dB + i) % DEPTH ||
            (i < obsData.size() ? obsData[i] : '0) !== mem[(dB + i) % DEPTH] ||
            (i < obsLast.size() ? obsLast[i] : 1'bx) !== (i == NR - 1)) begin
          nMismatched++; $display("[TB] FAIL rnd%0d_beat%0d: got addr %0d data %h expected addr %0d data %h",
                                  k, i, (i < obsAddr.size() ? obsAddr[i] : -1),
                                  (i < obsData.size() ? obsData[i] : '0), (dB + i) % DEPTH, mem[(dB + i) % DEPTH]);
        end
      end
      nCompared++;
      if (doneCycles != 1 || busyAfter !== 1'b0 || busyViol != 0 || stallViol != 0 || readViol != 0 ||
          obsData.size() != NR || obsAddr.size() != NR) begin
        nMismatched++; $display("[TB] FAIL rnd%0d_protocol: got done %0d busyAfter %b viol %0d/%0d/%0d beats %0d reads %0d expected 1/0/0/0/0/%0d/%0d",
                                k, doneCycles, busyAfter, busyViol, stallViol, readViol,
                                obsData.size(), obsAddr.size(), NR, NR);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_ignored_start();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sa_op_sequencer.md
SA_OP_SEQUENCER -- requirements
Module: sa_op_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROW, default 4, array rows.
REQ-002 SHALL have parameter NUM_COL, default 4, array columns.
REQ-003 SHALL have parameter ACCU_DATA_WIDTH, default 32, result width per column.
REQ-004 SHALL have parameter LOG2_SRAM_BANK_DEPTH (LD), default 5, SRAM address width.
REQ-005 SHALL have parameter CTRL_WIDTH, default 4, array control-state width.
REQ-006 SHALL use one clock, clk, and reset rst, which is asynchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 i_start  in  1  operation request pulse.
REQ-010 i_len  in  LD  K: SRAM rows per operand.
REQ-011 i_top_base / i_left_base / i_down_base  in  LD each  operand and result base addresses.
REQ-012 o_busy  out  1  operation in progress; o_done  out  1  one-cycle completion pulse.
REQ-013 o_ctrl_state  out  CTRL_WIDTH  array state: IDLE=0, WARMUP=1, STEADY=2, DRAIN=3.
REQ-014 o_top_sram_rd_start_addr/_end_addr, o_left_.., o_down_..  out  LD each  array read ranges.
REQ-015 o_down_rd_en  out  1; o_down_rd_addr  out  LD  result-buffer read port.
REQ-016 i_down_rd_data  in  NUM_COL*ACCU_DATA_WIDTH  read data, valid one cycle after o_down_rd_en.
REQ-017 o_res_valid  out  1; i_res_ready  in  1; o_res_data  out  NUM_COL*ACCU_DATA_WIDTH; o_res_last  out  1  result stream.

Function
REQ-018 FSM states: S_IDLE, S_WARMUP, S_STEADY, S_DRAIN, S_READOUT; o_ctrl_state = IDLE in S_IDLE and S_READOUT, else matching code.
REQ-019 i_start accepted only in S_IDLE with i_len != 0; i_len == 0 or start while busy SHALL be ignored (no state change, no done).
REQ-020 On accepted start, i_len and all bases SHALL be latched; o_busy rises next cycle and stays high until the cycle after o_done.
REQ-021 Range outputs: start = base, end = (base + len) mod 2^LD (exclusive end, wraps); held constant from latch until next accepted start.
REQ-022 S_WARMUP lasts len+1 cycles; S_STEADY lasts len+NUM_ROW+NUM_COL-2 cycles; S_DRAIN lasts NUM_ROW cycles; then S_READOUT.
REQ-023 Phase counter SHALL be wide enough for len_max+NUM_ROW+NUM_COL without overflow.
REQ-024 S_READOUT reads NUM_ROW words at addresses down_base+0..NUM_ROW-1, each mod 2^LD.
REQ-025 At most one read in flight; a read issues when none in flight and (no result held, or held result accepted this cycle).
REQ-026 Read data captured into o_res_data the cycle after o_down_rd_en; o_res_valid high the cycle after capture.
REQ-027 o_res_valid/o_res_data/o_res_last SHALL remain stable while o_res_valid && !i_res_ready.
REQ-028 o_res_last high with the NUM_ROW-th result only.
REQ-029 Acceptance of the last result SHALL pulse o_done the next cycle and return to S_IDLE in the same cycle.

Reset
REQ-030 rst SHALL force S_IDLE, counters 0, o_ctrl_state=IDLE, all addresses 0, o_down_rd_en=0, o_res_valid=0, o_res_data=0, o_res_last=0, o_busy=0, o_done=0.
REQ-031 rst asserted mid-operation SHALL abort it; in-flight reads and held results are discarded; no o_done.

Structure
REQ-032 Shared package sa_pkg SHALL hold array control-state codes (IDLE..DRAIN), CTRL_WIDTH and the sequencer FSM state type.
REQ-033 The readout engine (REQ-024..028) SHALL be one sub-module, sa_res_stream; phase FSM stays in the top.

Verification
REQ-034 len=4, bases 0/0/0, ready=1: o_ctrl_state 1 for 5 cycles, 2 for 10, 3 for 4; ranges 0->4; reads at 0,1,2,3; 4 beats, last on 4th; o_done once.
REQ-035 i_res_ready toggled 1-of-3 cycles: data held stable while stalled; exactly 4 beats in order; no read issued while result held unaccepted.
REQ-036 top_base=30, len=4: top range 30->2; down_base=30: reads 30,31,0,1.
REQ-037 i_start pulsed during S_STEADY and with len=0 in S_IDLE: ignored, one o_done total for the original op.
REQ-038 rst asserted during S_STEADY: all outputs to reset values next edge; subsequent start runs a clean full sequence.
